// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the mem_ctrl data-memory controller.
// The FORCE state exists only when MEM_CTRL_LOADER_EN is defined.
package mem_ctrl_pkg;

    localparam int HADDR_W = 19;
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SECOND = 2'd1
`ifdef MEM_CTRL_LOADER_EN
        ,
        ST_FORCE  = 2'd2
`endif
    } state_e;

    function automatic logic calc_misalign(input logic req, input logic word, input logic [1:0] lsb);
        return req && (lsb[0] || (word && lsb[1]));
    endfunction

endpackage

// File: rtl/mem_ctrl_starve.sv
// Loader starvation counter: counts cycles a loader request waits ungranted.
// hit flags the cycle the count reaches STARVE_MAX; pending flags an already-starved request.
module mem_ctrl_starve #(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ld_req,
    input  logic ld_gnt,
    output logic hit,
    output logic pending
);

    localparam logic [8:0] MAX_C = 9'(STARVE_MAX);

    logic [7:0] count_r;

    // Wait counter: clears on grant or idle request, saturates at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 8'd0;
        end else if (!ld_req || ld_gnt) begin
            count_r <= 8'd0;
        end else if (count_r != 8'hFF) begin
            count_r <= count_r + 8'd1;
        end
    end

    assign hit     = ld_req && !ld_gnt && (({1'b0, count_r} + 9'd1) >= MAX_C);
    assign pending = ld_req && ({1'b0, count_r} >= MAX_C);

endmodule

// File: rtl/mem_ctrl.sv
// Pipeline MEM-stage controller onto a 16-bit data memory; word accesses take two cycles, big-endian.
// Optional loader port sharing the memory is enabled by defining MEM_CTRL_LOADER_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 wr,
    input  logic                 word,
    input  logic                 dirty,
    input  logic                 skip,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 stall,
    output logic                 misalign,
    output logic                 mem_write,
    output logic [HADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]    mem_di,
    input  logic [DATA_W-1:0]    mem_do
`ifdef MEM_CTRL_LOADER_EN
    ,
    input  logic                 ld_req,
    input  logic                 ld_wr,
    input  logic [HADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]    ld_wdata,
    output logic                 ld_gnt,
    output logic [DATA_W-1:0]    ld_rdata
`endif
);

    state_e              state_r;
    state_e              next_s;
    logic [DATA_W-1:0]   hold_r;
    logic                wr_r;
    logic                hold_en_s;
    logic                misalign_s;
    logic                valid_s;
    logic [31:0]         rdata_s;
    logic                stall_s;
    logic                mem_write_s;
    logic [HADDR_W-1:0]  mem_addr_s;
    logic [DATA_W-1:0]   mem_di_s;
    logic                unused_s;

    assign unused_s   = ^addr[31:20];
    assign misalign_s = calc_misalign(req, word, addr[1:0]);
    assign valid_s    = req && !dirty && !skip && !misalign_s;

`ifdef MEM_CTRL_LOADER_EN
    logic ld_gnt_s;
    logic hit_s;
    logic pending_s;

    // A starved loader blocks the pipeline in IDLE until its FORCE cycle runs.
    assign ld_gnt_s = (state_r == ST_FORCE) ||
                      ((state_r == ST_IDLE) && !valid_s && !pending_s && ld_req);

    mem_ctrl_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_req  (ld_req),
        .ld_gnt  (ld_gnt_s),
        .hit     (hit_s),
        .pending (pending_s)
    );

    assign ld_gnt   = rst_n && ld_gnt_s;
    assign ld_rdata = rst_n ? mem_do : 16'h0000;
`endif

    // Next-state and memory-port steering for the current state.
    always_comb begin
        next_s      = state_r;
        hold_en_s   = 1'b0;
        rdata_s     = 32'h0000_0000;
        stall_s     = 1'b0;
        mem_write_s = 1'b0;
        mem_addr_s  = 19'h0_0000;
        mem_di_s    = 16'h0000;
        case (state_r)
            ST_IDLE: begin
`ifdef MEM_CTRL_LOADER_EN
                if (pending_s) begin
                    stall_s = 1'b1;
                    next_s  = ST_FORCE;
                end else
`endif
                if (valid_s) begin
                    mem_addr_s  = addr[19:1];
                    mem_write_s = wr;
                    if (word) begin
                        mem_di_s  = wdata[31:16];
                        stall_s   = 1'b1;
                        hold_en_s = 1'b1;
                        next_s    = ST_SECOND;
                    end else begin
                        mem_di_s  = wdata[15:0];
                        rdata_s   = {16'h0000, mem_do};
                    end
                end else begin
`ifdef MEM_CTRL_LOADER_EN
                    if (ld_gnt_s) begin
                        mem_addr_s  = ld_addr;
                        mem_write_s = ld_wr;
                        mem_di_s    = ld_wdata;
                    end else begin
                        mem_addr_s  = 19'h0_0000;
                    end
`else
                    mem_addr_s = 19'h0_0000;
`endif
                end
`ifdef MEM_CTRL_LOADER_EN
                // A word starting now finishes before the forced loader cycle.
                if (hit_s && !(valid_s && word)) begin
                    next_s = ST_FORCE;
                end else begin
                    hold_en_s = hold_en_s && !pending_s;
                end
`endif
            end
            ST_SECOND: begin
                mem_addr_s  = addr[19:1] + 19'd1;
                mem_write_s = wr_r;
                mem_di_s    = wdata[15:0];
                rdata_s     = {hold_r, mem_do};
                next_s      = ST_IDLE;
            end
`ifdef MEM_CTRL_LOADER_EN
            ST_FORCE: begin
                stall_s     = 1'b1;
                mem_addr_s  = ld_addr;
                mem_write_s = ld_wr;
                mem_di_s    = ld_wdata;
                next_s      = ST_IDLE;
            end
`endif
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // State, high-half hold register and latched store enable for the second cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            hold_r  <= 16'h0000;
            wr_r    <= 1'b0;
        end else begin
            state_r <= next_s;
            if (hold_en_s) begin
                hold_r <= mem_do;
                wr_r   <= wr;
            end
        end
    end

    assign rdata     = rst_n ? rdata_s : 32'h0000_0000;
    assign stall     = rst_n && stall_s;
    assign misalign  = rst_n && misalign_s;
    assign mem_write = rst_n && mem_write_s;
    assign mem_addr  = rst_n ? mem_addr_s : 19'h0_0000;
    assign mem_di    = rst_n ? mem_di_s : 16'h0000;

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: STARVE_MAX, 8, consecutive cycles a pending loader request waits before it forces a grant (range 1..255).
REQ-002 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst_n  in  1  one clock; reset is asynchronous and active-low.
REQ-004 Port: req  in  1  pipeline MEM-stage access valid.
REQ-005 Port: wr  in  1  pipeline access is a store.
REQ-006 Port: word  in  1  1 = 32-bit access, 0 = 16-bit half access.
REQ-007 Port: dirty, skip  in  1 each  pipeline protect/skip; either high voids the access.
REQ-008 Port: addr  in  32  byte address; bits [19:0] used.
REQ-009 Port: wdata  in  32  store data; half stores use [15:0].
REQ-010 Port: rdata  out  32  load data.
REQ-011 Port: stall  out  1  freeze pipeline this cycle.
REQ-012 Port: misalign  out  1  access rejected for alignment.
REQ-013 Port: mem_write  out  1  data-memory write strobe.
REQ-014 Port: mem_addr  out  19  halfword address to data memory.
REQ-015 Port: mem_di  out  16  write data to data memory.
REQ-016 Port: mem_do  in  16  read data from data memory, combinational on mem_addr.
REQ-017 Ports present only under MEM_CTRL_LOADER_EN: ld_req in 1, ld_wr in 1, ld_addr in 19, ld_wdata in 16, ld_gnt out 1, ld_rdata out 16 (= mem_do).

Function
REQ-018 FSM states: IDLE, SECOND, (LOADER_EN only) FORCE.
REQ-019 Pipeline access is valid when req && !dirty && !skip && !misalign; an invalid access performs no write, no stall.
REQ-020 misalign = req && (addr[0] || (word && addr[1])), combinational.
REQ-021 Half access: single cycle in IDLE; mem_addr = addr[19:1]; mem_write = wr; mem_di = wdata[15:0]; rdata = {16'h0, mem_do}; stall = 0.
REQ-022 Word access, big-endian: IDLE cycle accesses addr[19:1] with wdata[31:16], latches mem_do into hold register, stall = 1, next = SECOND.
REQ-023 SECOND cycle accesses addr[19:1]+1 with wdata[15:0]; rdata = {hold, mem_do}; stall = 0; next = IDLE; total latency 2 cycles.
REQ-024 Write enable for SECOND uses wr latched in IDLE; dirty/skip sampled in IDLE only, a change during SECOND has no effect.
REQ-025 When no access is active: mem_write = 0, mem_addr = 0, mem_di = 0, rdata = 0.

Reset
REQ-026 On rst_n low: state = IDLE, hold = 0, starvation counter = 0; all outputs 0 while rst_n low.
REQ-027 Reset asserted in SECOND aborts the word; second half is not written.

Configuration
REQ-028 Macro MEM_CTRL_LOADER_EN: when defined, a loader port shares data memory; when undefined, loader ports, FORCE state and counter are absent and behaviour is REQ-018..027 only.
REQ-029 With macro: pipeline has priority; ld_gnt = ld_req when state is IDLE and no valid pipeline access; granted loader drives mem_addr/mem_write/mem_di same cycle.
REQ-030 With macro: counter increments each cycle ld_req is high and not granted, clears on grant or ld_req low; at STARVE_MAX, next state = FORCE (only from IDLE; a word in progress completes first).
REQ-031 FORCE: ld_gnt = 1, stall = 1, pipeline access ignored, counter clears, next = IDLE.

Structure
REQ-032 Shared package holds FSM state enum, halfword address width (19) and data width (16).
REQ-033 Starvation counter is a natural sub-module: mem_ctrl_starve.

Verification
REQ-034 Half store addr=0x100 wdata=0xBEEF -> one cycle, mem_addr=0x80, mem_write=1, stall=0.
REQ-035 Word load addr=0x200, memory 0x100=0x1234, 0x101=0x5678 -> stall=1 then rdata=0x12345678.
REQ-036 Word store addr=0x202 -> misalign=1, mem_write=0, stall=0; half addr=0x3 -> misalign=1.
REQ-037 Word store with skip rising in SECOND -> both halves written; rst_n low in SECOND -> second half unwritten, state IDLE.
REQ-038 LOADER_EN, STARVE_MAX=8, pipeline req held with ld_req -> ld_gnt=0 for 8 cycles, then FORCE cycle with ld_gnt=1, stall=1.
